// File: rtl/ad_ip_jesd204_tpl_dac_sync_buffer.sv
// Elastic sample buffer in the link clock domain between the DMA and the TPL DAC framer.
// Beats are released once armed, the fill threshold is met and, optionally, sync_in is seen.
module ad_ip_jesd204_tpl_dac_sync_buffer #(
  parameter int NUM_CHANNELS    = 2,
  parameter int DATA_PATH_WIDTH = 2,
  parameter int BITS_PER_SAMPLE = 16,
  parameter int FIFO_DEPTH      = 16,
  localparam int W  = NUM_CHANNELS * DATA_PATH_WIDTH * BITS_PER_SAMPLE,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                    link_clk,
  input  logic                    link_resetn,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [W-1:0]            s_data,
  input  logic [NUM_CHANNELS-1:0] enable,
  input  logic                    arm_req,
  input  logic                    stop_req,
  input  logic                    sync_mode,
  input  logic                    sync_in,
  input  logic [AW:0]             start_threshold,
  input  logic                    unf_mode,
  input  logic                    unf_clr,
  input  logic                    m_ready,
  output logic                    m_valid,
  output logic [W-1:0]            m_data,
  output logic                    armed,
  output logic                    running,
  output logic                    underflow,
  output logic                    underflow_sticky,
  output logic [AW:0]             fill_level
);

  localparam int CW = DATA_PATH_WIDTH * BITS_PER_SAMPLE;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = (AW)'(1);

  typedef enum logic [1:0] {IDLE, ARMED, RUNNING} state_t;

  state_t        state, state_next;
  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next, start_level;
  logic          push, pop, unf_event, start_ok;

  function automatic logic [W-1:0] apply_mask(input logic [W-1:0] d,
                                              input logic [NUM_CHANNELS-1:0] en);
    logic [W-1:0] r;
    r = d;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (!en[c]) r[c*CW +: CW] = '0;
    return r;
  endfunction

  // A beat offered in a stop cycle is dropped, and nothing is read while stopping.
  assign push      = s_valid && s_ready && !stop_req;
  assign pop       = (state == RUNNING) && m_ready && !stop_req && (count != '0);
  assign unf_event = (state == RUNNING) && m_ready && !stop_req && (count == '0);

  assign start_level = (start_threshold > DEPTH_C) ? DEPTH_C : start_threshold;
  assign start_ok    = (count >= start_level) && (!sync_mode || sync_in);

  always_comb begin
    state_next = state;
    if (stop_req) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (arm_req) state_next = ARMED;
        ARMED:   if (start_ok) state_next = RUNNING;
        RUNNING: state_next = RUNNING;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    count_next = count;
    if (stop_req)
      count_next = '0;
    else if (push && !pop)
      count_next = count + CNT_ONE;
    else if (pop && !push)
      count_next = count - CNT_ONE;
  end

  always_ff @(posedge link_clk or negedge link_resetn) begin
    if (!link_resetn) begin
      state   <= IDLE;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      s_ready <= 1'b1;
    end else begin
      state   <= state_next;
      count   <= count_next;
      s_ready <= (count_next < DEPTH_C);
      if (stop_req) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge link_clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // Output register: pop, underflow fill, or hold when the link stalls.
  always_ff @(posedge link_clk or negedge link_resetn) begin
    if (!link_resetn) begin
      m_valid          <= 1'b0;
      m_data           <= '0;
      underflow        <= 1'b0;
      underflow_sticky <= 1'b0;
    end else begin
      underflow <= unf_event;
      if (unf_event)
        underflow_sticky <= 1'b1;
      else if (unf_clr)
        underflow_sticky <= 1'b0;

      if (stop_req || state != RUNNING) begin
        m_valid <= 1'b0;
        m_data  <= '0;
      end else if (m_ready) begin
        m_valid <= 1'b1;
        if (pop)
          m_data <= apply_mask(mem[rd_ptr], enable);
        else
          m_data <= apply_mask(unf_mode ? m_data : '0, enable);
      end
    end
  end

  assign armed      = (state == ARMED);
  assign running    = (state == RUNNING);
  assign fill_level = count;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_sync_buffer.sv
// Directed self-checking bench for the DAC sync buffer with default parameters
// (two channels, 64-bit beats, 16-beat depth).
module tb_ad_ip_jesd204_tpl_dac_sync_buffer;

  localparam int W  = 64;
  localparam int AW = 4;

  logic          link_clk = 1'b0;
  logic          link_resetn;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic [1:0]    enable;
  logic          arm_req, stop_req, sync_mode, sync_in;
  logic [AW:0]   start_threshold;
  logic          unf_mode, unf_clr, m_ready;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          armed, running, underflow, underflow_sticky;
  logic [AW:0]   fill_level;

  int assertCount = 0;
  int failCount   = 0;

  ad_ip_jesd204_tpl_dac_sync_buffer dut (
    .link_clk(link_clk), .link_resetn(link_resetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .enable(enable), .arm_req(arm_req), .stop_req(stop_req),
    .sync_mode(sync_mode), .sync_in(sync_in), .start_threshold(start_threshold),
    .unf_mode(unf_mode), .unf_clr(unf_clr), .m_ready(m_ready),
    .m_valid(m_valid), .m_data(m_data), .armed(armed), .running(running),
    .underflow(underflow), .underflow_sticky(underflow_sticky),
    .fill_level(fill_level)
  );

  always #5 link_clk = ~link_clk;

  function automatic logic [W-1:0] beat(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'h0000_1000 + 32'(i)};
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge link_clk);
    #1;
  endtask

  // One-cycle push of a single beat.
  task automatic applyStimulus(input logic [W-1:0] data);
    s_valid = 1'b1;
    s_data  = data;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic pulseStop(input logic clr);
    stop_req = 1'b1;
    unf_clr  = clr;
    tick();
    stop_req = 1'b0;
    unf_clr  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    link_resetn = 1'b0;
    s_valid = 0; s_data = '0; enable = 2'b11; arm_req = 0; stop_req = 0;
    sync_mode = 0; sync_in = 0; start_threshold = '0; unf_mode = 0;
    unf_clr = 0; m_ready = 0;
    repeat (2) @(posedge link_clk);
    #1;
    checkOutput("rst_s_ready", W'(s_ready), 64'd1);
    checkOutput("rst_m_valid", W'(m_valid), 64'd0);
    checkOutput("rst_m_data", m_data, 64'd0);
    checkOutput("rst_fill", W'(fill_level), 64'd0);
    checkOutput("rst_state", W'({armed, running, underflow, underflow_sticky}), 64'd0);
    link_resetn = 1'b1;

    // 1: threshold start, latency and ordering
    start_threshold = 5'd4;
    m_ready = 1'b1;
    arm_req = 1'b1; tick(); arm_req = 1'b0;
    checkOutput("t1_armed", W'(armed), 64'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(beat(i));
      checkOutput("t1_fill", W'(fill_level), 64'(i + 1));
    end
    checkOutput("t1_not_running_yet", W'(running), 64'd0);
    tick();
    checkOutput("t1_running", W'(running), 64'd1);
    checkOutput("t1_m_valid_lag", W'(m_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("t1_m_valid", W'(m_valid), 64'd1);
      checkOutput("t1_m_data", m_data, beat(i));
      checkOutput("t1_fill_drain", W'(fill_level), 64'(3 - i));
    end
    tick();
    checkOutput("t1_underflow", W'(underflow), 64'd1);
    checkOutput("t1_zero_fill", m_data, 64'd0);
    checkOutput("t1_sticky", W'(underflow_sticky), 64'd1);
    pulseStop(1'b1);
    checkOutput("t1_stop_idle", W'({armed, running, m_valid, underflow, underflow_sticky}), 64'd0);

    // 2: sync-gated start
    sync_mode = 1'b1;
    start_threshold = 5'd2;
    for (int i = 0; i < 8; i++) applyStimulus(beat(16 + i));
    arm_req = 1'b1; tick(); arm_req = 1'b0;
    repeat (10) tick();
    checkOutput("t2_still_armed", W'({armed, running}), 64'b10);
    checkOutput("t2_no_valid", W'(m_valid), 64'd0);
    checkOutput("t2_fill", W'(fill_level), 64'd8);
    sync_in = 1'b1; tick(); sync_in = 1'b0;
    checkOutput("t2_running", W'(running), 64'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("t2_m_data", m_data, beat(16 + i));
    end
    pulseStop(1'b0);
    checkOutput("t2_no_sticky", W'(underflow_sticky), 64'd0);
    sync_mode = 1'b0;

    // 3: full buffer back-pressure
    m_ready = 1'b0;
    start_threshold = 5'd16;
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = beat(32 + i);
      tick();
    end
    s_valid = 1'b0;
    checkOutput("t3_fill_full", W'(fill_level), 64'd16);
    checkOutput("t3_s_ready_low", W'(s_ready), 64'd0);
    arm_req = 1'b1; m_ready = 1'b1; tick(); arm_req = 1'b0;
    tick();
    checkOutput("t3_running", W'(running), 64'd1);
    for (int i = 0; i < 16; i++) begin
      tick();
      checkOutput("t3_m_data", m_data, beat(32 + i));
      if (i == 0) checkOutput("t3_s_ready_back", W'(s_ready), 64'd1);
    end
    tick();
    checkOutput("t3_exactly16", W'(underflow), 64'd1);
    pulseStop(1'b1);

    // 4: underflow fill policies and sticky clear
    unf_mode = 1'b1;
    start_threshold = 5'd3;
    applyStimulus(beat(48));
    applyStimulus(beat(49));
    applyStimulus(64'h1234_0000_AAAA_5555);
    arm_req = 1'b1; tick(); arm_req = 1'b0;
    tick();
    repeat (3) tick();
    checkOutput("t4_last", m_data, 64'h1234_0000_AAAA_5555);
    checkOutput("t4_no_unf_yet", W'(underflow), 64'd0);
    tick();
    checkOutput("t4_hold1", m_data, 64'h1234_0000_AAAA_5555);
    checkOutput("t4_unf1", W'(underflow), 64'd1);
    tick();
    checkOutput("t4_hold2", m_data, 64'h1234_0000_AAAA_5555);
    checkOutput("t4_unf2", W'(underflow), 64'd1);
    checkOutput("t4_sticky", W'(underflow_sticky), 64'd1);
    unf_mode = 1'b0;
    tick();
    checkOutput("t4_zero", m_data, 64'd0);
    unf_clr = 1'b1;
    tick();
    checkOutput("t4_sticky_wins", W'(underflow_sticky), 64'd1);
    m_ready = 1'b0;
    tick();
    unf_clr = 1'b0;
    checkOutput("t4_unf_stop", W'(underflow), 64'd0);
    checkOutput("t4_sticky_clr", W'(underflow_sticky), 64'd0);

    // 5: channel enable masking
    enable = 2'b01;
    applyStimulus(64'h9ABC_DEF0_1234_5678);
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    checkOutput("t5_en01", m_data, 64'h0000_0000_1234_5678);
    enable = 2'b10;
    applyStimulus(64'h9ABC_DEF0_1234_5678);
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    checkOutput("t5_en10", m_data, 64'h9ABC_DEF0_0000_0000);
    enable = 2'b11;

    // 6: stop beats arm and flushes; async reset
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = beat(64 + i);
      tick();
    end
    checkOutput("t6_fill10", W'(fill_level), 64'd10);
    stop_req = 1'b1; arm_req = 1'b1;
    tick();
    stop_req = 1'b0; arm_req = 1'b0; s_valid = 1'b0;
    checkOutput("t6_idle", W'({armed, running}), 64'd0);
    checkOutput("t6_flush", W'(fill_level), 64'd0);
    checkOutput("t6_m_valid", W'(m_valid), 64'd0);
    start_threshold = 5'd2;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(beat(80 + i));
    arm_req = 1'b1; tick(); arm_req = 1'b0;
    tick();
    tick();
    checkOutput("t6_after_flush", m_data, beat(80));
    link_resetn = 1'b0;
    #2;
    checkOutput("t6_rst_m_valid", W'(m_valid), 64'd0);
    checkOutput("t6_rst_m_data", m_data, 64'd0);
    checkOutput("t6_rst_state", W'({armed, running, underflow_sticky}), 64'd0);
    checkOutput("t6_rst_fill", W'(fill_level), 64'd0);
    checkOutput("t6_rst_s_ready", W'(s_ready), 64'd1);
    link_resetn = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
